// File: rtl/stats_bank.sv
// stats_bank: per-channel packet-length FIFOs drained round-robin into packet/octet counters.
// Define STATS_BANK_SATURATE_EN to make counters hold at all-ones instead of wrapping.
module stats_bank #(
  parameter int NUM_CH  = 2,
  parameter int LEN_W   = 14,
  parameter int CNT_W   = 32,
  parameter int FIFO_AW = 2
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NUM_CH-1:0]       sfifo_wen,
  input  logic [NUM_CH*LEN_W-1:0] sfifo_wdata,
  output logic [NUM_CH-1:0]       sfifo_full,
  input  logic [NUM_CH-1:0]       clear_pkts,
  input  logic [NUM_CH-1:0]       clear_octets,
  output logic [NUM_CH*CNT_W-1:0] stats_pkts,
  output logic [NUM_CH*CNT_W-1:0] stats_octets
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  typedef logic [FIFO_AW:0] ptr_t;

  logic [LEN_W-1:0] mem_q [NUM_CH][DEPTH];
  logic [LEN_W-1:0] mem_d [NUM_CH][DEPTH];
  ptr_t             wr_ptr_q [NUM_CH];
  ptr_t             wr_ptr_d [NUM_CH];
  ptr_t             wr_vis_q [NUM_CH];
  ptr_t             wr_vis_d [NUM_CH];
  ptr_t             rd_ptr_q [NUM_CH];
  ptr_t             rd_ptr_d [NUM_CH];
  logic [NUM_CH-1:0] full_q, full_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic              s0_vld_q, s0_vld_d;
  logic [CH_W-1:0]   s0_ch_q, s0_ch_d;
  logic [LEN_W-1:0]  s0_len_q, s0_len_d;
  logic [CNT_W-1:0]  pkts_q [NUM_CH];
  logic [CNT_W-1:0]  pkts_d [NUM_CH];
  logic [CNT_W-1:0]  oct_q [NUM_CH];
  logic [CNT_W-1:0]  oct_d [NUM_CH];
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_ch;
  logic [NUM_CH-1:0] wr_en, rd_en, avail;

  function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] base,
                                               input logic [CNT_W-1:0] inc);
`ifdef STATS_BANK_SATURATE_EN
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
    return base + inc;
`endif
  endfunction

  // The arbiter sees a write pointer delayed by one edge, so a record becomes
  // poppable two edges after it is written and can never be over-popped.
  always_comb begin
    int idx;
    idx     = 0;
    avail   = '0;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) avail[i] = (wr_vis_q[i] != rd_ptr_q[i]);
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_vld && avail[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_t occ;
    occ    = '0;
    mem_d  = mem_q;
    wr_en  = '0;
    rd_en  = '0;
    full_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_en[i]    = sfifo_wen[i] && !full_q[i];
      rd_en[i]    = gnt_vld && (gnt_ch == CH_W'(i));
      wr_ptr_d[i] = wr_ptr_q[i] + ptr_t'(wr_en[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + ptr_t'(rd_en[i]);
      wr_vis_d[i] = wr_ptr_q[i];
      occ         = wr_ptr_d[i] - rd_ptr_d[i];
      full_d[i]   = occ[FIFO_AW];
      if (wr_en[i]) mem_d[i][wr_ptr_q[i][FIFO_AW-1:0]] = sfifo_wdata[i*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    s0_vld_d = gnt_vld;
    s0_ch_d  = gnt_ch;
    s0_len_d = mem_q[gnt_ch][rd_ptr_q[gnt_ch][FIFO_AW-1:0]];
    rr_d     = rr_q;
    if (gnt_vld) rr_d = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
  end

  // A clear coinciding with an update restarts the counter from the update.
  always_comb begin
    logic             upd;
    logic [CNT_W-1:0] p_base, o_base;
    upd    = 1'b0;
    p_base = '0;
    o_base = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      upd       = s0_vld_q && (s0_ch_q == CH_W'(i));
      p_base    = clear_pkts[i] ? '0 : pkts_q[i];
      o_base    = clear_octets[i] ? '0 : oct_q[i];
      pkts_d[i] = upd ? cnt_add(p_base, CNT_W'(1)) : p_base;
      oct_d[i]  = upd ? cnt_add(o_base, CNT_W'(s0_len_q)) : o_base;
    end
  end

  always_comb begin
    stats_pkts   = '0;
    stats_octets = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      stats_pkts[i*CNT_W +: CNT_W]   = pkts_q[i];
      stats_octets[i*CNT_W +: CNT_W] = oct_q[i];
    end
  end

  assign sfifo_full = full_q;

  always_ff @(posedge wb_clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        wr_vis_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        pkts_q[i]   <= '0;
        oct_q[i]    <= '0;
      end
      full_q   <= '0;
      rr_q     <= '0;
      s0_vld_q <= 1'b0;
      s0_ch_q  <= '0;
      s0_len_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      wr_vis_q <= wr_vis_d;
      rd_ptr_q <= rd_ptr_d;
      pkts_q   <= pkts_d;
      oct_q    <= oct_d;
      full_q   <= full_d;
      rr_q     <= rr_d;
      s0_vld_q <= s0_vld_d;
      s0_ch_q  <= s0_ch_d;
      s0_len_q <= s0_len_d;
    end
  end
endmodule

// File: tb/tb_stats_bank.sv
// Bench for stats_bank: cycle-stepped reference model with per-channel expected queues,
// plus directed checks for latency, contention, clear collisions and wrap/saturation.
module tb_stats_bank;
  localparam int NUM_CH  = 2;
  localparam int LEN_W   = 14;
  localparam int CNT_W   = 8;
  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam longint MAX = (64'd1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       sfifo_wen = '0;
  logic [NUM_CH*LEN_W-1:0] sfifo_wdata = '0;
  logic [NUM_CH-1:0]       sfifo_full;
  logic [NUM_CH-1:0]       clear_pkts = '0;
  logic [NUM_CH-1:0]       clear_octets = '0;
  logic [NUM_CH*CNT_W-1:0] stats_pkts;
  logic [NUM_CH*CNT_W-1:0] stats_octets;

  stats_bank #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .CNT_W(CNT_W), .FIFO_AW(FIFO_AW)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .sfifo_wen    (sfifo_wen),
    .sfifo_wdata  (sfifo_wdata),
    .sfifo_full   (sfifo_full),
    .clear_pkts   (clear_pkts),
    .clear_octets (clear_octets),
    .stats_pkts   (stats_pkts),
    .stats_octets (stats_octets)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: records waiting per channel with the edge they were written on.
  logic [LEN_W-1:0]  exp_q [NUM_CH][$];
  int                exp_t [NUM_CH][$];
  logic [NUM_CH-1:0] m_full = '0;
  int                m_rr = 0;
  logic              m_s0_vld = 1'b0;
  int                m_s0_ch = 0;
  logic [LEN_W-1:0]  m_s0_len = '0;
  logic [CNT_W-1:0]  m_pkts [NUM_CH];
  logic [CNT_W-1:0]  m_oct [NUM_CH];
  int                acc_cnt [NUM_CH];
  int                edge_n = 0;
  logic [NUM_CH-1:0] seen_full = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] m_add(input logic [CNT_W-1:0] b, input int a);
    longint s;
    s = longint'(b) + longint'(a);
`ifdef STATS_BANK_SATURATE_EN
    if (s > MAX) s = MAX;
`endif
    return CNT_W'(s);
  endfunction

  function automatic logic [CNT_W-1:0] dut_pkts(input int c);
    return stats_pkts[c*CNT_W +: CNT_W];
  endfunction

  function automatic logic [CNT_W-1:0] dut_oct(input int c);
    return stats_octets[c*CNT_W +: CNT_W];
  endfunction

  // One clock: drive inputs, advance the model to the coming edge, then compare.
  task automatic step(input logic [NUM_CH-1:0] wen, input logic [LEN_W-1:0] len0,
                      input logic [LEN_W-1:0] len1, input logic [NUM_CH-1:0] cp,
                      input logic [NUM_CH-1:0] co, input logic r);
    logic [LEN_W-1:0] lens [NUM_CH];
    logic gv;
    int gc, c;
    lens[0] = len0;
    lens[1] = len1;
    sfifo_wen    = wen;
    sfifo_wdata  = {len1, len0};
    clear_pkts   = cp;
    clear_octets = co;
    rst          = r;
    edge_n++;
    if (r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        exp_q[i].delete();
        exp_t[i].delete();
        m_pkts[i] = '0;
        m_oct[i]  = '0;
      end
      m_full   = '0;
      m_rr     = 0;
      m_s0_vld = 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cp[i]) m_pkts[i] = '0;
        if (co[i]) m_oct[i] = '0;
        if (m_s0_vld && m_s0_ch == i) begin
          m_pkts[i] = m_add(m_pkts[i], 1);
          m_oct[i]  = m_add(m_oct[i], int'(m_s0_len));
        end
      end
      gv = 1'b0;
      gc = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_rr + k) % NUM_CH;
        if (!gv && exp_q[c].size() > 0 && exp_t[c][0] <= edge_n - 2) begin
          gv = 1'b1;
          gc = c;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (wen[i] && !m_full[i]) begin
          exp_q[i].push_back(lens[i]);
          exp_t[i].push_back(edge_n);
          acc_cnt[i]++;
        end
      end
      m_s0_vld = gv;
      if (gv) begin
        m_s0_ch  = gc;
        m_s0_len = exp_q[gc].pop_front();
        void'(exp_t[gc].pop_front());
        m_rr = (gc + 1) % NUM_CH;
      end
      for (int i = 0; i < NUM_CH; i++) m_full[i] = (exp_q[i].size() == DEPTH);
    end
    @(posedge clk);
    #1;
    seen_full = seen_full | sfifo_full;
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("pkts%0d", i), 32'(dut_pkts(i)), 32'(m_pkts[i]));
      check($sformatf("oct%0d", i), 32'(dut_oct(i)), 32'(m_oct[i]));
      check($sformatf("full%0d", i), 32'(sfifo_full[i]), 32'(m_full[i]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    int sat_exp;
    for (int i = 0; i < NUM_CH; i++) begin
      m_pkts[i]  = '0;
      m_oct[i]   = '0;
      acc_cnt[i] = 0;
    end

    // Reset state
    for (int i = 0; i < 3; i++) step('0, '0, '0, '0, '0, 1'b1);
    check("rst_pkts0", 32'(dut_pkts(0)), 0);
    check("rst_oct1", 32'(dut_oct(1)), 0);
    check("rst_full", 32'(sfifo_full), 0);

    // Uncontended latency: visible exactly three edges after the write
    step(2'b01, 14'd64, '0, '0, '0, 1'b0);
    idle(2);
    check("lat_early_pkts0", 32'(dut_pkts(0)), 0);
    idle(1);
    check("lat_pkts0", 32'(dut_pkts(0)), 1);
    check("lat_oct0", 32'(dut_oct(0)), 64);
    check("lat_pkts1", 32'(dut_pkts(1)), 0);

    // Contention: both channels write every cycle for 8 cycles
    step('0, '0, '0, 2'b11, 2'b11, 1'b0);
    for (int i = 0; i < NUM_CH; i++) acc_cnt[i] = 0;
    seen_full = '0;
    for (int i = 0; i < 8; i++) step(2'b11, 14'd10, 14'd20, '0, '0, 1'b0);
    idle(14);
    check("cont_seen_full0", 32'(seen_full[0]), 1);
    check("cont_seen_full1", 32'(seen_full[1]), 1);
    check("cont_pkts0", 32'(dut_pkts(0)), 32'(acc_cnt[0]));
    check("cont_pkts1", 32'(dut_pkts(1)), 32'(acc_cnt[1]));
    check("cont_oct0", 32'(dut_oct(0)), 32'(10 * acc_cnt[0]));
    check("cont_oct1", 32'(dut_oct(1)), 32'(20 * acc_cnt[1]));

    // Clear colliding with a stage-1 update, then an independent octet clear
    step('0, '0, '0, 2'b11, 2'b11, 1'b0);
    step(2'b01, 14'd50, '0, '0, '0, 1'b0);
    idle(3);
    check("pre_clr_oct0", 32'(dut_oct(0)), 50);
    step(2'b01, 14'd100, '0, '0, '0, 1'b0);
    idle(2);
    step('0, '0, '0, 2'b01, '0, 1'b0);
    check("clr_hit_pkts0", 32'(dut_pkts(0)), 1);
    check("clr_hit_oct0", 32'(dut_oct(0)), 150);
    step('0, '0, '0, '0, 2'b01, 1'b0);
    check("clr_oct_only_oct0", 32'(dut_oct(0)), 0);
    check("clr_oct_only_pkts0", 32'(dut_pkts(0)), 1);

    // Octet counter overflow: wrap or saturate
    step('0, '0, '0, 2'b11, 2'b11, 1'b0);
    step(2'b01, 14'd250, '0, '0, '0, 1'b0);
    idle(3);
    check("preload_oct0", 32'(dut_oct(0)), 250);
    step(2'b01, 14'd10, '0, '0, '0, 1'b0);
    idle(3);
`ifdef STATS_BANK_SATURATE_EN
    sat_exp = 255;
`else
    sat_exp = 4;
`endif
    check("ovf_oct0", 32'(dut_oct(0)), 32'(sat_exp));
    check("ovf_pkts0", 32'(dut_pkts(0)), 2);

    // Reset while records are buffered: nothing is counted afterwards
    for (int i = 0; i < 3; i++) step(2'b11, 14'd7, 14'd9, '0, '0, 1'b0);
    step('0, '0, '0, '0, '0, 1'b1);
    check("mid_rst_pkts0", 32'(dut_pkts(0)), 0);
    check("mid_rst_full", 32'(sfifo_full), 0);
    idle(6);
    check("post_rst_pkts0", 32'(dut_pkts(0)), 0);
    check("post_rst_pkts1", 32'(dut_pkts(1)), 0);
    check("post_rst_oct0", 32'(dut_oct(0)), 0);
    check("post_rst_oct1", 32'(dut_oct(1)), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
